// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache.
// Hits are answered combinationally in the request cycle. A miss fetches one
// 256-bit line from physical memory in a single read handshake, installs it,
// and the fetch stage re-looks-up and hits on the following cycle.
// Saturating hit/miss counters are provided for performance bring-up.
module icache_direct #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         icache_read,
    input  logic [31:0]  icache_address,
    output logic         icache_resp,
    output logic [31:0]  icache_rdata,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic [26:0]   r_miss_line;      // line address (bits [31:5]) of the pending miss
    logic [31:0]   r_hit_count;
    logic [31:0]   r_miss_count;

    // ------------------------------------------------------------------
    // Request address decomposition
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]   w_req_tag;
    logic [S_INDEX-1:0] w_req_index;
    logic [2:0]         w_req_word;

    assign w_req_tag   = icache_address[31:5+S_INDEX];
    assign w_req_index = icache_address[4+S_INDEX:5];
    assign w_req_word  = icache_address[4:2];

    // Fill target derived from the captured miss address, not the live
    // request address, so address changes during FETCH cannot redirect it.
    logic [TAG_W-1:0]   w_fill_tag;
    logic [S_INDEX-1:0] w_fill_index;
    logic               w_fill;

    assign w_fill_tag   = r_miss_line[26:S_INDEX];
    assign w_fill_index = r_miss_line[S_INDEX-1:0];
    assign w_fill       = (r_state == ST_FETCH) && pmem_resp;

    // ------------------------------------------------------------------
    // Per-set storage: valid bit, tag and one 256-bit line
    // ------------------------------------------------------------------
    logic [SETS-1:0]  w_valid_vec;
    logic [TAG_W-1:0] w_tag_arr  [SETS];
    logic [255:0]     w_line_arr [SETS];

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_set
            logic             r_valid;
            logic [TAG_W-1:0] r_tag;
            logic [255:0]     r_line;
            logic             w_set_fill;

            assign w_set_fill = w_fill && (w_fill_index == S_INDEX'(gi));

            // Valid bit: cleared by reset, set when this set is filled.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                end else if (w_set_fill) begin
                    r_valid <= 1'b1;
                end
            end

            // Tag and line contents need no reset; the valid bit guards them.
            always_ff @(posedge clk) begin
                if (w_set_fill) begin
                    r_tag  <= w_fill_tag;
                    r_line <= pmem_rdata;
                end
            end

            assign w_valid_vec[gi] = r_valid;
            assign w_tag_arr[gi]   = r_tag;
            assign w_line_arr[gi]  = r_line;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic         w_lookup_hit;
    logic         w_hit;
    logic [255:0] w_sel_line;
    logic [7:0]   w_word_offset;

    assign w_lookup_hit  = w_valid_vec[w_req_index] && (w_tag_arr[w_req_index] == w_req_tag);
    assign w_hit         = (r_state == ST_IDLE) && icache_read && w_lookup_hit;
    assign w_sel_line    = w_line_arr[w_req_index];
    assign w_word_offset = {w_req_word, 5'b0_0000};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic w_miss;

    // Next-state logic: a missing request in IDLE opens a fetch, which
    // closes on the memory response.
    always_comb begin
        w_state_next = r_state;
        w_miss       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (icache_read && !w_lookup_hit) begin
                    w_miss       = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pmem_resp) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and miss address capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_miss_line <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_miss) begin
                r_miss_line <= icache_address[31:5];
            end
        end
    end

    // Output decode: response only on an IDLE hit; memory address is
    // zeroed whenever no line fetch is requested.
    always_comb begin
        icache_resp  = w_hit;
        icache_rdata = w_sel_line[w_word_offset +: 32];
        pmem_read    = (r_state == ST_FETCH);
        pmem_address = 32'h0;
        if (r_state == ST_FETCH) begin
            pmem_address = {r_miss_line, 5'b0_0000};
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (saturating, a miss counts once on entry)
    // ------------------------------------------------------------------
    // Hit counter: one per hit cycle, held at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hit_count <= '0;
        end else if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
            r_hit_count <= r_hit_count + 32'd1;
        end
    end

    // Miss counter: one per IDLE->FETCH transition, held at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_miss_count <= '0;
        end else if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge. Expected instruction words
// are queued when a hit request is driven and popped when icache_resp is seen.
module tb_icache_direct;

    logic         clk;
    logic         reset_n;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic         icache_resp;
    logic [31:0]  icache_rdata;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    icache_direct #(.S_INDEX(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .pmem_read      (pmem_read),
        .pmem_address   (pmem_address),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Memory model: wait (bounded) for pmem_read, hold for 'waits' cycles,
    // then pulse pmem_resp with the line. Returns at the first cycle after
    // the install edge.
    task automatic mem_respond(input logic [31:0] base, input int waits,
                               output logic [31:0] first_addr, output bit seen,
                               output bit stable);
        seen = 1'b0;
        stable = 1'b1;
        first_addr = 32'h0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (pmem_read === 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen) return;
        first_addr = pmem_address;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (pmem_read !== 1'b1 || pmem_address !== first_addr || icache_resp !== 1'b0)
                stable = 1'b0;
        end
        pmem_rdata = make_line(base);
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        icache_read = 1'b0;
        icache_address = 32'h0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: resp=%b pmem_read=%b pmem_addr=%h want 0/0/0",
                     icache_resp, pmem_read, pmem_address);
        end
        total++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_counters: hit=%h miss=%h want 0/0", hit_count, miss_count);
        end
        tick();
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_cold_miss();
        logic [31:0] a;
        bit seen, stable;
        tick();
        icache_read = 1'b1;
        icache_address = 32'h0000_0060;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL cold_miss_resp: got=%b want=0", icache_resp);
        end
        tick();
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h60) begin
            bad++;
            $display("FAIL cold_fetch_req: pmem_read=%b addr=%h want 1/00000060", pmem_read, pmem_address);
        end
        mem_respond(32'hA000_0000, 2, a, seen, stable);
        total++;
        if (!seen || a !== 32'h60 || !stable) begin
            bad++;
            $display("FAIL cold_fill: seen=%b addr=%h stable=%b want 1/00000060/1", seen, a, stable);
        end
        exp_q.push_back(32'hA000_0000);
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b1) begin
            bad++;
            $display("FAIL cold_relookup_resp: got=%b want=1", icache_resp);
        end else if (exp_q.size() > 0) begin
            logic [31:0] e = exp_q.pop_front();
            if (icache_rdata !== e) begin
                bad++;
                $display("FAIL cold_relookup_data: got=%h want=%h", icache_rdata, e);
            end
        end
        tick();
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            bad++;
            $display("FAIL cold_counts: hit=%0d miss=%0d want 1/1", hit_count, miss_count);
        end
        $display("cold miss 0x60: hit=%0d miss=%0d", hit_count, miss_count);
    endtask

    task automatic test_line_hits();
        for (int k = 1; k < 8; k++) begin
            tick();
            icache_read = 1'b1;
            icache_address = 32'h60 + 32'(4 * k);
            exp_q.push_back(32'hA000_0000 + 32'(k));
            @(negedge clk);
            total++;
            if (icache_resp !== 1'b1 || pmem_read !== 1'b0) begin
                bad++;
                $display("FAIL line_hit_%0d: resp=%b pmem_read=%b want 1/0", k, icache_resp, pmem_read);
            end
            if (icache_resp === 1'b1 && exp_q.size() > 0) begin
                logic [31:0] e = exp_q.pop_front();
                total++;
                if (icache_rdata !== e) begin
                    bad++;
                    $display("FAIL line_hit_data_%0d: got=%h want=%h", k, icache_rdata, e);
                end
            end
            $display("hit addr=%h rdata=%h", icache_address, icache_rdata);
        end
        tick();
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (hit_count !== 32'd8 || miss_count !== 32'd1) begin
            bad++;
            $display("FAIL line_hits_counts: hit=%0d miss=%0d want 8/1", hit_count, miss_count);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] a;
        bit seen, stable;
        tick();
        icache_read = 1'b1;
        icache_address = 32'h160;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL conflict_miss_resp: got=%b want=0", icache_resp);
        end
        tick();
        mem_respond(32'hB000_0000, 1, a, seen, stable);
        total++;
        if (!seen || a !== 32'h160 || !stable) begin
            bad++;
            $display("FAIL conflict_fill: seen=%b addr=%h stable=%b want 1/00000160/1", seen, a, stable);
        end
        exp_q.push_back(32'hB000_0000);
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b1) begin
            bad++;
            $display("FAIL conflict_relookup_resp: got=%b want=1", icache_resp);
        end else if (exp_q.size() > 0) begin
            logic [31:0] e = exp_q.pop_front();
            if (icache_rdata !== e) begin
                bad++;
                $display("FAIL conflict_relookup_data: got=%h want=%h", icache_rdata, e);
            end
        end
        tick();
        icache_address = 32'h60;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL conflict_evicted_resp: got=%b want=0", icache_resp);
        end
        tick();
        mem_respond(32'hA000_0000, 0, a, seen, stable);
        total++;
        if (!seen || a !== 32'h60) begin
            bad++;
            $display("FAIL conflict_refetch: seen=%b addr=%h want 1/00000060", seen, a);
        end
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (hit_count !== 32'd9 || miss_count !== 32'd3) begin
            bad++;
            $display("FAIL conflict_counts: hit=%0d miss=%0d want 9/3", hit_count, miss_count);
        end
        $display("conflict 0x160/0x60: hit=%0d miss=%0d", hit_count, miss_count);
    endtask

    task automatic test_addr_change();
        logic [31:0] a;
        bit seen, stable;
        tick();
        icache_read = 1'b1;
        icache_address = 32'h200;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL chg_miss_resp: got=%b want=0", icache_resp);
        end
        tick();
        icache_address = 32'h300;
        mem_respond(32'hC000_0000, 3, a, seen, stable);
        total++;
        if (!seen || a !== 32'h200 || !stable) begin
            bad++;
            $display("FAIL chg_fill_addr: seen=%b addr=%h stable=%b want 1/00000200/1", seen, a, stable);
        end
        icache_address = 32'h200;
        exp_q.push_back(32'hC000_0000);
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b1) begin
            bad++;
            $display("FAIL chg_200_hit: got=%b want=1", icache_resp);
        end else if (exp_q.size() > 0) begin
            logic [31:0] e = exp_q.pop_front();
            if (icache_rdata !== e) begin
                bad++;
                $display("FAIL chg_200_data: got=%h want=%h", icache_rdata, e);
            end
        end
        tick();
        icache_address = 32'h300;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL chg_300_miss: got=%b want=0", icache_resp);
        end
        tick();
        mem_respond(32'hD000_0000, 1, a, seen, stable);
        total++;
        if (!seen || a !== 32'h300) begin
            bad++;
            $display("FAIL chg_300_fetch: seen=%b addr=%h want 1/00000300", seen, a);
        end
        icache_address = 32'h304;
        exp_q.push_back(32'hD000_0001);
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b1) begin
            bad++;
            $display("FAIL chg_304_hit: got=%b want=1", icache_resp);
        end else if (exp_q.size() > 0) begin
            logic [31:0] e = exp_q.pop_front();
            if (icache_rdata !== e) begin
                bad++;
                $display("FAIL chg_304_data: got=%h want=%h", icache_rdata, e);
            end
        end
        tick();
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (hit_count !== 32'd11 || miss_count !== 32'd5) begin
            bad++;
            $display("FAIL chg_counts: hit=%0d miss=%0d want 11/5", hit_count, miss_count);
        end
        $display("addr change 0x200->0x300: hit=%0d miss=%0d", hit_count, miss_count);
    endtask

    task automatic test_reset_in_fetch();
        logic [31:0] a;
        bit seen, stable;
        tick();
        icache_read = 1'b1;
        icache_address = 32'h400;
        tick();
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h400) begin
            bad++;
            $display("FAIL rst_fetch_pre: pmem_read=%b addr=%h want 1/00000400", pmem_read, pmem_address);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b0 || pmem_address !== 32'h0 || icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL rst_fetch_abort: pmem_read=%b addr=%h resp=%b want 0/0/0",
                     pmem_read, pmem_address, icache_resp);
        end
        tick();
        pmem_rdata = make_line(32'hE000_0000);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        icache_read = 1'b1;
        icache_address = 32'h400;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL rst_late_resp_ignored: resp=%b want=0", icache_resp);
        end
        total++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            bad++;
            $display("FAIL rst_counters: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
        end
        tick();
        mem_respond(32'hE000_0000, 1, a, seen, stable);
        icache_address = 32'h60;
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b0) begin
            bad++;
            $display("FAIL rst_60_misses: resp=%b want=0", icache_resp);
        end
        tick();
        mem_respond(32'hA000_0000, 0, a, seen, stable);
        total++;
        if (!seen || a !== 32'h60) begin
            bad++;
            $display("FAIL rst_60_fetch: seen=%b addr=%h want 1/00000060", seen, a);
        end
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (hit_count !== 32'h0 || miss_count !== 32'd2) begin
            bad++;
            $display("FAIL rst_after_counts: hit=%0d miss=%0d want 0/2", hit_count, miss_count);
        end
        $display("reset in fetch: hit=%0d miss=%0d", hit_count, miss_count);
    endtask

    task automatic test_idle_and_saturate();
        for (int i = 0; i < 10; i++) begin
            tick();
            icache_read = 1'b0;
            icache_address = $urandom & 32'hFFFF_FFFC;
            @(negedge clk);
            total++;
            if (icache_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
                bad++;
                $display("FAIL idle_%0d: resp=%b pmem_read=%b addr=%h want 0/0/0",
                         i, icache_resp, pmem_read, pmem_address);
            end
        end
        tick();
        total++;
        if (hit_count !== 32'h0 || miss_count !== 32'd2) begin
            bad++;
            $display("FAIL idle_counts: hit=%0d miss=%0d want 0/2", hit_count, miss_count);
        end
        force dut.r_hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_hit_count;
        tick();
        icache_read = 1'b1;
        icache_address = 32'h68;
        exp_q.push_back(32'hA000_0002);
        @(negedge clk);
        total++;
        if (icache_resp !== 1'b1) begin
            bad++;
            $display("FAIL sat_hit_resp: got=%b want=1", icache_resp);
        end else if (exp_q.size() > 0) begin
            logic [31:0] e = exp_q.pop_front();
            if (icache_rdata !== e) begin
                bad++;
                $display("FAIL sat_hit_data: got=%h want=%h", icache_rdata, e);
            end
        end
        tick();
        icache_read = 1'b0;
        @(negedge clk);
        total++;
        if (hit_count !== 32'hFFFF_FFFF || miss_count !== 32'd2) begin
            bad++;
            $display("FAIL sat_counts: hit=%h miss=%0d want ffffffff/2", hit_count, miss_count);
        end
        $display("saturation: hit=%h miss=%0d", hit_count, miss_count);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_line_hits();
        test_conflict();
        test_addr_change();
        test_reset_in_fetch();
        test_idle_and_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
